// File: rtl/mips_multicycle.sv
// Multicycle MIPS subset core (add/sub/and/or/slt, addi, lw, sw, beq, j).
// One instruction walks FETCH -> DECODE -> EXECUTE [-> MEMORY] [-> WRITEBACK]
// over a single request/ready memory port shared by fetch and data.
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   mem_req/mem_we        registered request strobe and store flag
//   mem_addr/mem_wdata    registered byte address (low ADDR_W bits) and store data
//   mem_ready/mem_rdata   completion handshake and read data from memory
//   retire                one-cycle pulse per completed instruction
//   illegal               sticky halt flag (unsupported opcode or misaligned access)
//   pc_out                architectural PC
module mips_multicycle #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32
) (
    input  logic              clock,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata,
    output logic              retire,
    output logic              illegal,
    output logic [31:0]       pc_out
);

    localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04,
                           OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24,
                           F_OR = 6'h25, F_SLT = 6'h2A;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_HALT
    } state_t;

    state_t              state_q, state_d;
    logic [31:0]         pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d;
    logic [31:0]         imm_q, imm_d, alu_q, alu_d, mdr_q, mdr_d;
    logic                mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic [31:0]         rf_q [32];
    logic                rf_we;
    logic [4:0]          rf_waddr;
    logic [31:0]         rf_wdata;
    logic                mem_done;
    logic [5:0]          opcode;

    function automatic logic is_legal(input logic [31:0] ins);
        logic ok;
        case (ins[31:26])
            OP_R:                               ok = ins[5:0] inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT};
            OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: ok = 1'b1;
            default:                            ok = 1'b0;
        endcase
        return ok;
    endfunction

    // ready only counts while a request is actually on the bus
    assign mem_done = mem_req_q & mem_ready;
    assign opcode   = ir_q[31:26];

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        imm_d    = imm_q;
        alu_d    = alu_q;
        mdr_d    = mdr_q;
        rf_we    = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = 32'd0;
        retire   = 1'b0;
        case (state_q)
            S_FETCH: if (mem_done) begin
                ir_d    = mem_rdata;
                pc_d    = pc_q + 32'd4;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                a_d     = rf_q[ir_q[25:21]];
                b_d     = rf_q[ir_q[20:16]];
                imm_d   = {{16{ir_q[15]}}, ir_q[15:0]};
                state_d = is_legal(ir_q) ? S_EXECUTE : S_HALT;
            end
            S_EXECUTE: case (opcode)
                OP_BEQ: begin
                    if (a_q == b_q) pc_d = pc_q + (imm_q << 2);
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
                OP_J: begin
                    pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
                OP_LW, OP_SW: begin
                    alu_d   = a_q + imm_q;
                    // misaligned: halt before any data request goes out
                    state_d = (alu_d[1:0] != 2'b00) ? S_HALT : S_MEMORY;
                end
                OP_ADDI: begin
                    alu_d   = a_q + imm_q;
                    state_d = S_WRITEBACK;
                end
                default: begin
                    case (ir_q[5:0])
                        F_SUB:   alu_d = a_q - b_q;
                        F_AND:   alu_d = a_q & b_q;
                        F_OR:    alu_d = a_q | b_q;
                        F_SLT:   alu_d = {31'd0, $signed(a_q) < $signed(b_q)};
                        default: alu_d = a_q + b_q;
                    endcase
                    state_d = S_WRITEBACK;
                end
            endcase
            S_MEMORY: if (mem_done) begin
                if (opcode == OP_SW) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    mdr_d   = mem_rdata;
                    state_d = S_WRITEBACK;
                end
            end
            S_WRITEBACK: begin
                rf_we    = 1'b1;
                rf_waddr = (opcode == OP_R) ? ir_q[15:11] : ir_q[20:16];
                rf_wdata = (opcode == OP_LW) ? mdr_q : alu_q;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            default: ;
        endcase

        // Bus outputs are registered against the state being entered, so they
        // line up with state_q and stay frozen while a transaction waits.
        mem_req_d   = (state_d == S_FETCH) || (state_d == S_MEMORY);
        mem_we_d    = (state_d == S_MEMORY) && (opcode == OP_SW);
        mem_addr_d  = (state_d == S_FETCH) ? pc_d[ADDR_W-1:0] : alu_d[ADDR_W-1:0];
        mem_wdata_d = (state_d == S_MEMORY) ? b_q : mem_wdata_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            ir_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            imm_q       <= '0;
            alu_q       <= '0;
            mdr_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            a_q         <= a_d;
            b_q         <= b_d;
            imm_q       <= imm_d;
            alu_q       <= alu_d;
            mdr_q       <= mdr_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // register 0 is never written, so it always reads back as zero
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else if (rf_we && (rf_waddr != 5'd0)) begin
            rf_q[rf_waddr] <= rf_wdata;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign illegal   = (state_q == S_HALT);
    assign pc_out    = pc_q;

endmodule

// File: tb/tb_mips_multicycle.sv
// Bench for mips_multicycle: an instruction-level reference model predicts
// every bus transaction, retire latency and retire-time PC; directed programs
// add hand-computed expectations on top.
module tb_mips_multicycle;

    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req, mem_we, retire, illegal;
    logic        mem_ready = 1'b1;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out;

    mips_multicycle #(.RESET_PC(RPC), .ADDR_W(32)) dut (
        .clock(clock), .reset(reset),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .retire(retire), .illegal(illegal), .pc_out(pc_out)
    );

    always #5 clock = ~clock;

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // ---------------- memory responder ----------------
    logic [31:0] tbmem [256];
    int          stall_cnt = 0, stall_seen = 0;
    bit          hold_we = 1'b0;
    logic [31:0] log_addr[$], log_wd[$];
    bit          log_we[$];

    assign mem_rdata = tbmem[mem_addr[9:2]];

    always @(negedge clock) begin
        if (!reset && mem_req && mem_ready) begin
            log_addr.push_back(mem_addr);
            log_we.push_back(mem_we);
            log_wd.push_back(mem_wdata);
            if (mem_we) tbmem[mem_addr[9:2]] = mem_wdata;
        end
    end

    always @(posedge clock) begin
        #1;
        if (mem_req && hold_we && mem_we) begin
            mem_ready = 1'b0;
            stall_seen++;
        end else if (mem_req && stall_cnt > 0) begin
            mem_ready = 1'b0;
            stall_cnt--;
            stall_seen++;
        end else begin
            mem_ready = 1'b1;
        end
    end

    // ---------------- instruction-level reference model ----------------
    logic [31:0] m_mem [256];
    logic [31:0] m_rf [32];
    logic [31:0] m_pc, inst_pc;
    logic [31:0] q_addr[$], q_wd[$];
    bit          q_we[$];
    bit          have_inst, m_halt;
    int          cyc, inst_start, waits, base;
    int          ret_cyc[$];

    task automatic expect_acc(input logic [31:0] a, input bit we, input logic [31:0] d);
        q_addr.push_back(a);
        q_we.push_back(we);
        q_wd.push_back(d);
    endtask

    // Executes one whole instruction architecturally and queues the bus
    // accesses it must produce.
    task automatic model_step();
        logic [31:0] ins, a, b, imm, ea, npc;
        ins = m_mem[m_pc[9:2]];
        inst_pc = m_pc;
        npc = m_pc + 32'd4;
        have_inst = 1'b1;
        inst_start = 0;
        waits = 0;
        base = 4;
        expect_acc(m_pc, 1'b0, 32'd0);
        a   = m_rf[ins[25:21]];
        b   = m_rf[ins[20:16]];
        imm = {{16{ins[15]}}, ins[15:0]};
        ea  = a + imm;
        case (ins[31:26])
            6'h00: case (ins[5:0])
                6'h20: m_rf[ins[15:11]] = a + b;
                6'h22: m_rf[ins[15:11]] = a - b;
                6'h24: m_rf[ins[15:11]] = a & b;
                6'h25: m_rf[ins[15:11]] = a | b;
                6'h2A: m_rf[ins[15:11]] = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                default: m_halt = 1'b1;
            endcase
            6'h08: m_rf[ins[20:16]] = ea;
            6'h23: begin
                base = 5;
                if (ea[1:0] != 2'b00) m_halt = 1'b1;
                else begin
                    expect_acc(ea, 1'b0, 32'd0);
                    m_rf[ins[20:16]] = m_mem[ea[9:2]];
                end
            end
            6'h2B: begin
                if (ea[1:0] != 2'b00) m_halt = 1'b1;
                else begin
                    expect_acc(ea, 1'b1, b);
                    m_mem[ea[9:2]] = b;
                end
            end
            6'h04: begin
                base = 3;
                if (a == b) npc = npc + (imm << 2);
            end
            6'h02: begin
                base = 3;
                npc = {npc[31:28], ins[25:0], 2'b00};
            end
            default: m_halt = 1'b1;
        endcase
        m_rf[0] = 32'd0;
        if (!m_halt) m_pc = npc;
    endtask

    // compare process: DUT outputs against the model every cycle
    always @(negedge clock) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) m_mem[i] = tbmem[i];
            for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
            m_pc = RPC;
            have_inst = 1'b0;
            m_halt = 1'b0;
            cyc = 0;
            q_addr.delete(); q_we.delete(); q_wd.delete();
            ret_cyc.delete();
        end else begin
            cyc++;
            if (!have_inst) model_step();
            if (mem_req) begin
                if (q_addr.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL bus_unexpected: mem_req=1 addr %h while no access is due", mem_addr);
                end else begin
                    chk("bus_addr", mem_addr, q_addr[0]);
                    chk("bus_we", {31'd0, mem_we}, {31'd0, q_we[0]});
                    if (q_we[0]) chk("bus_wdata", mem_wdata, q_wd[0]);
                    if (inst_start == 0) inst_start = cyc;
                    if (mem_ready) begin
                        void'(q_addr.pop_front()); void'(q_we.pop_front()); void'(q_wd.pop_front());
                    end else waits++;
                end
            end
            if (retire) begin
                n_chk++;
                if (m_halt || q_addr.size() != 0) begin
                    n_fail++;
                    $display("FAIL retire_ok: retire at cycle %0d, halt=%0d pending=%0d required 0/0", cyc, m_halt, q_addr.size());
                end
                chk("latency", cyc - inst_start + 1, base + waits);
                chk("pc_at_retire", pc_out, inst_pc + 32'd4);
                ret_cyc.push_back(cyc);
                have_inst = 1'b0;
            end
            if (illegal) begin
                n_chk++;
                if (!(m_halt && q_addr.size() == 0)) begin
                    n_fail++;
                    $display("FAIL illegal_ok: illegal=1 at cycle %0d, required 0", cyc);
                end
            end
        end
    end

    // ---------------- directed phases ----------------
    task automatic put(input logic [31:0] a, input logic [31:0] w);
        tbmem[a[9:2]] = w;
    endtask

    task automatic start_reset();
        reset = 1'b1;
        for (int i = 0; i < 256; i++) tbmem[i] = 32'd0;
    endtask

    task automatic release_reset();
        repeat (2) @(negedge clock);
        #1;
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_retire", {31'd0, retire}, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        chk("rst_pc", pc_out, RPC);
        log_addr.delete(); log_we.delete(); log_wd.delete();
        stall_seen = 0;
        reset = 1'b0;
    endtask

    task automatic wait_illegal(input int budget);
        int k = 0;
        while (!illegal && k < budget) begin
            @(negedge clock); #1; k++;
        end
        chk("halt_reached", {31'd0, illegal}, 32'd1);
    endtask

    task automatic check_stores(input logic [31:0] ea[], input logic [31:0] ed[]);
        int s = 0;
        for (int i = 0; i < log_addr.size(); i++) begin
            if (log_we[i]) begin
                if (s < ea.size()) begin
                    chk("store_addr", log_addr[i], ea[s]);
                    chk("store_data", log_wd[i], ed[s]);
                end
                s++;
            end
        end
        chk("store_count", s, ea.size());
    endtask

    initial begin
        logic [31:0] pc_hold;
        int k, nlog;

        // Phase 1: ALU ops, j, sw/lw round trip, $0 discard, beq not taken, bad opcode
        start_reset();
        put(32'h00, 32'h20010005); put(32'h04, 32'h20020007); put(32'h08, 32'h00221820);
        put(32'h0C, 32'h08000040);
        put(32'h100, 32'hAC030010); put(32'h104, 32'h8C040010); put(32'h108, 32'hAC040014);
        put(32'h10C, 32'h00222822); put(32'h110, 32'h00A1302A); put(32'h114, 32'h00223824);
        put(32'h118, 32'h00224025); put(32'h11C, 32'h00220020); put(32'h120, 32'hAC050018);
        put(32'h124, 32'hAC06001C); put(32'h128, 32'hAC070020); put(32'h12C, 32'hAC080024);
        put(32'h130, 32'hAC000028); put(32'h134, 32'h10220005); put(32'h138, 32'h2009FFFF);
        put(32'h13C, 32'h0121502A); put(32'h140, 32'hAC0A002C); put(32'h144, 32'hFC000000);
        release_reset();
        wait_illegal(400);
        chk("p1_retires", ret_cyc.size(), 21);
        if (ret_cyc.size() >= 6) begin
            chk("p1_ret0", ret_cyc[0], 4);
            chk("p1_ret1", ret_cyc[1], 8);
            chk("p1_ret2", ret_cyc[2], 12);
            chk("p1_j_lat", ret_cyc[3] - ret_cyc[2], 3);
            chk("p1_sw_lat", ret_cyc[4] - ret_cyc[3], 4);
            chk("p1_lw_lat", ret_cyc[5] - ret_cyc[4], 5);
        end
        if (log_addr.size() >= 5) chk("p1_fetch_after_j", log_addr[4], 32'h100);
        check_stores('{32'h10, 32'h14, 32'h18, 32'h1C, 32'h20, 32'h24, 32'h28, 32'h2C},
                     '{32'd12, 32'd12, 32'hFFFF_FFFE, 32'd1, 32'd5, 32'd7, 32'd0, 32'd1});
        chk("p1_halt_pc", pc_out, 32'h148);
        nlog = log_addr.size();
        repeat (6) @(negedge clock);
        #1;
        chk("p1_pc_frozen", pc_out, 32'h148);
        chk("p1_illegal_sticky", {31'd0, illegal}, 32'd1);
        chk("p1_no_more_access", log_addr.size(), nlog);

        // Phase 2: 3-cycle fetch stall, j, beq backwards, misaligned lw
        start_reset();
        put(32'h00, 32'h20010003); put(32'h04, 32'h08000008);
        put(32'h20, 32'h1021FFFE); put(32'h1C, 32'h8C220010);
        stall_cnt = 3;
        release_reset();
        wait_illegal(200);
        chk("p2_retires", ret_cyc.size(), 3);
        if (ret_cyc.size() >= 1) chk("p2_stalled_ret0", ret_cyc[0], 7);
        chk("p2_stall_cycles", stall_seen, 3);
        chk("p2_access_count", log_addr.size(), 4);
        if (log_addr.size() >= 4) begin
            chk("p2_fetch_j_target", log_addr[2], 32'h20);
            chk("p2_fetch_beq_target", log_addr[3], 32'h1C);
        end
        chk("p2_halt_pc", pc_out, 32'h20);

        // Phase 3: reset while a store is waiting in MEMORY
        start_reset();
        put(32'h00, 32'h20010009); put(32'h04, 32'hAC010040);
        put(32'h08, 32'h8C020040); put(32'h0C, 32'hAC020044); put(32'h10, 32'hFC000000);
        hold_we = 1'b1;
        release_reset();
        k = 0;
        while (!(mem_req && mem_we) && k < 50) begin
            @(negedge clock); #1; k++;
        end
        chk("p3_store_pending", {31'd0, mem_req && mem_we}, 32'd1);
        repeat (2) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk("p3_req_drops", {31'd0, mem_req}, 32'd0);
        chk("p3_we_drops", {31'd0, mem_we}, 32'd0);
        chk("p3_pc_reset", pc_out, RPC);
        chk("p3_no_store", tbmem[16], 32'd0);
        hold_we = 1'b0;
        log_addr.delete(); log_we.delete(); log_wd.delete();
        repeat (2) @(negedge clock);
        #1 reset = 1'b0;
        wait_illegal(200);
        if (log_addr.size() >= 1) chk("p3_restart_fetch", log_addr[0], RPC);
        chk("p3_retires", ret_cyc.size(), 4);
        check_stores('{32'h40, 32'h44}, '{32'd9, 32'd9});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not complete, required completion");
        $fatal(1);
    end

endmodule

// File: doc/mips_multicycle.md
MIPS_MULTICYCLE -- requirements
Module: mips_multicycle

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter ADDR_W, default 32: mem_addr width; mem_addr carries the low ADDR_W bits of the 32-bit byte address.
REQ-003 clock  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 mem_req  out  1  memory transaction request.
REQ-006 mem_we  out  1  1 = store, 0 = load/fetch; valid while mem_req=1.
REQ-007 mem_addr  out  ADDR_W  byte address, word aligned.
REQ-008 mem_wdata  out  32  store data.
REQ-009 mem_ready  in  1  transaction completes on a cycle with mem_req=1 and mem_ready=1.
REQ-010 mem_rdata  in  32  read data, sampled on the completing cycle.
REQ-011 retire  out  1  one-cycle pulse per completed instruction.
REQ-012 illegal  out  1  sticky; core halted on an unsupported instruction or misaligned access.
REQ-013 pc_out  out  32  current architectural PC.

Function
REQ-014 States SHALL be FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT; one-hot or binary at implementer's choice.
REQ-015 FETCH: mem_req=1, mem_we=0, mem_addr=pc; hold until mem_ready; on completion IR<=mem_rdata, pc<=pc+4, go to DECODE.
REQ-016 DECODE: A<=reg[IR[25:21]], B<=reg[IR[20:16]], imm<=sign-extended IR[15:0]; unsupported opcode/funct goes to HALT, else EXECUTE.
REQ-017 Supported: opcode 0 funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed); opcode 0x08 addi, 0x23 lw, 0x2B sw, 0x04 beq, 0x02 j.
REQ-018 Arithmetic SHALL be 32-bit wrap-around; no overflow traps.
REQ-019 EXECUTE beq: if A==B then pc<=pc+(imm<<2), pc being the already-incremented value; retire; go to FETCH.
REQ-020 EXECUTE j: pc<={pc[31:28],IR[25:0],2'b00}; retire; go to FETCH.
REQ-021 EXECUTE R-type/addi: ALUOut<=result; go to WRITEBACK.
REQ-022 EXECUTE lw/sw: ALUOut<=A+imm; if ALUOut[1:0]!=0 go to HALT without issuing a request, else MEMORY.
REQ-023 MEMORY: mem_req=1, mem_addr=ALUOut, mem_we=(sw), mem_wdata=B; on completion sw retires and goes to FETCH, lw captures MDR<=mem_rdata and goes to WRITEBACK.
REQ-024 WRITEBACK: R-type writes rd=IR[15:11]; addi/lw write rt=IR[20:16]; retire; go to FETCH.
REQ-025 Writes to register 0 SHALL be discarded; register 0 SHALL read 0.
REQ-026 mem_req, mem_we, mem_addr and mem_wdata SHALL be registered and held stable while mem_req=1 and mem_ready=0.
REQ-027 mem_ready while mem_req=0 SHALL be ignored.
REQ-028 Latency with mem_ready tied high: beq/j 3 cycles; R-type/addi/sw 4; lw 5; each wait cycle adds 1.
REQ-029 HALT: illegal=1, mem_req=0, retire=0, pc_out frozen; only reset exits.
REQ-030 pc_out SHALL update exactly on the cycle the pc register changes.

Reset
REQ-031 While reset=1: state=FETCH, pc=RESET_PC, mem_req=0, mem_we=0, retire=0, illegal=0, IR/A/B/ALUOut/MDR=0, all 32 registers=0.
REQ-032 Reset SHALL act immediately mid-transaction; mem_req drops asynchronously, with no completion or register write.
REQ-033 First fetch request SHALL appear in the first cycle after reset deasserts.

Verification
REQ-034 mem_ready=1; addi $1,$0,5; addi $2,$0,7; add $3,$1,$2 -> $3=12, retire pulses at cycles 4, 8, 12.
REQ-035 sw $3,16($0) then lw $4,16($0) -> store addr 0x10 data 12 with mem_we=1; $4=12; lw takes 5 cycles.
REQ-036 beq $1,$1,-2 at 0x20 -> next fetch at 0x1C; j 0x40 -> next fetch address 0x100.
REQ-037 mem_ready held low 3 cycles during fetch -> mem_req/mem_addr stable throughout, instruction latency +3.
REQ-038 Opcode 0x3F, or lw at address 0x13 -> illegal=1, no further mem_req or retire; reset clears to PC=RESET_PC.
REQ-039 reset asserted mid-MEMORY of sw -> mem_req falls immediately, no register write, fetch restarts at RESET_PC.
